// File: rtl/write_address_gen_pkg.sv
// Shared FIFO package: default geometry and Gray/binary pointer conversions.
// Used by both the write-side and the read-side address generators.
// Conversions work on a 32-bit container. Callers zero-extend narrower
// pointers and truncate the result, which is exact for both directions
// because leading zero Gray bits map to leading zero binary bits.
package write_address_gen_pkg;

  localparam int FIFO_ADDR_WIDTH  = 5;
  localparam int FIFO_AFULL_LEVEL = 28;

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  // Binary bit i is the XOR of Gray bits 31..i.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

endpackage

// File: rtl/write_address_gen_gray2bin.sv
// gray2bin: combinational Gray-to-binary converter of parameterized width.
//   gray_i : Gray-coded input  [WIDTH-1:0]
//   bin_o  : binary output     [WIDTH-1:0]
module gray2bin
  import write_address_gen_pkg::*;
#(
  parameter int WIDTH = FIFO_ADDR_WIDTH + 1
) (
  input  logic [WIDTH-1:0] gray_i,
  output logic [WIDTH-1:0] bin_o
);

  assign bin_o = WIDTH'(write_address_gen_pkg::gray2bin(32'(gray_i)));

endmodule

// File: rtl/write_address_gen.sv
// write_address_gen: write-side pointer logic of an async FIFO.
// Keeps a binary write pointer, exports its Gray form to the read side,
// and derives full / almost-full / level from the synchronized read pointer.
//   w_clk, reset    : write clock, async active-high reset
//   w_en            : producer write request
//   sync_read_ptr   : Gray read pointer already synchronized into w_clk
//   overflow_clr    : clears sticky w_overflow
//   w_address       : memory address for the current write
//   w_write         : memory write strobe (w_en & ~w_full)
//   w_ptr           : registered Gray write pointer
//   w_full, w_almost_full, w_level : registered status
//   w_overflow      : sticky, a write was attempted while full
module write_address_gen
  import write_address_gen_pkg::*;
#(
  parameter int ADDR_WIDTH  = FIFO_ADDR_WIDTH,
  parameter int AFULL_LEVEL = FIFO_AFULL_LEVEL
) (
  input  logic                  w_clk,
  input  logic                  reset,
  input  logic                  w_en,
  input  logic [ADDR_WIDTH:0]   sync_read_ptr,
  input  logic                  overflow_clr,
  output logic [ADDR_WIDTH-1:0] w_address,
  output logic                  w_write,
  output logic [ADDR_WIDTH:0]   w_ptr,
  output logic                  w_full,
  output logic                  w_almost_full,
  output logic [ADDR_WIDTH:0]   w_level,
  output logic                  w_overflow
);

  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH:0] AFULL_TH = PW'(AFULL_LEVEL);

  logic [ADDR_WIDTH:0] w_bin_q, w_bin_d;
  logic [ADDR_WIDTH:0] w_ptr_q, w_ptr_d;
  logic [ADDR_WIDTH:0] w_level_q, w_level_d;
  logic                w_full_q, w_full_d;
  logic                w_afull_q, w_afull_d;
  logic                w_ovf_q, w_ovf_d;
  logic [ADDR_WIDTH:0] r_bin;
  logic [ADDR_WIDTH:0] rptr_wrapped;

  gray2bin #(.WIDTH(PW)) u_rptr_g2b (
    .gray_i (sync_read_ptr),
    .bin_o  (r_bin)
  );

  always_comb begin
    w_write   = w_en & ~w_full_q;
    w_bin_d   = w_bin_q + PW'(w_write);
    w_ptr_d   = PW'(bin2gray(32'(w_bin_d)));
    // Full when the writer is exactly one lap ahead: in Gray code that is
    // the top two bits inverted and the rest equal.
    rptr_wrapped = {~sync_read_ptr[ADDR_WIDTH:ADDR_WIDTH-1],
                    sync_read_ptr[ADDR_WIDTH-2:0]};
    w_full_d  = (w_ptr_d == rptr_wrapped);
    // A stale read pointer only makes this larger, never smaller.
    w_level_d = w_bin_d - r_bin;
    w_afull_d = (w_level_d >= AFULL_TH);
    w_ovf_d   = w_ovf_q;
    if (overflow_clr)      w_ovf_d = 1'b0;
    if (w_en && w_full_q)  w_ovf_d = 1'b1;  // set wins over clear
  end

  always_ff @(posedge w_clk or posedge reset) begin
    if (reset) begin
      w_bin_q   <= '0;
      w_ptr_q   <= '0;
      w_level_q <= '0;
      w_full_q  <= 1'b0;
      w_afull_q <= 1'b0;
      w_ovf_q   <= 1'b0;
    end else begin
      w_bin_q   <= w_bin_d;
      w_ptr_q   <= w_ptr_d;
      w_level_q <= w_level_d;
      w_full_q  <= w_full_d;
      w_afull_q <= w_afull_d;
      w_ovf_q   <= w_ovf_d;
    end
  end

  assign w_address     = w_bin_q[ADDR_WIDTH-1:0];
  assign w_ptr         = w_ptr_q;
  assign w_full        = w_full_q;
  assign w_almost_full = w_afull_q;
  assign w_level       = w_level_q;
  assign w_overflow    = w_ovf_q;

endmodule
